// File: rtl/c16_mdu_if.sv
// Request/result bundle for the c16_mdu iterative multiply/divide unit.
// The requester holds the master side; the unit holds the slave side.
interface c16_mdu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             dz;

    modport master (output start, op, a, b, input busy, done, lo, hi, dz);
    modport slave  (input start, op, a, b, output busy, done, lo, hi, dz);
endinterface

// File: rtl/c16_mdu.sv
// Iterative multiply/divide unit: one result bit per cycle, fixed WIDTH+2 cycle latency.
// state | meaning
// IDLE  | waiting for start
// CALC  | WIDTH shift-add (mul) or restoring shift-subtract (div) iterations
// FIX   | apply result signs, handle divide-by-zero, load lo/hi/dz
// DONE  | done pulse; a new start is accepted here as in IDLE
module c16_mdu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input logic         clk,
    input logic         resetn,
    c16_mdu_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         op_r;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   a_r, opd;
    logic [2*WIDTH-1:0] acc, calc_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   lo_r, hi_r;
    logic               dz_r;
    logic               busy, done, accept, last_iter;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_lo, res_hi;
    logic               res_dz;

    assign accept    = bus.start && (state == IDLE || state == DONE);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign mag_a     = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b     = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.lo   = lo_r;
    assign bus.hi   = hi_r;
    assign bus.dz   = dz_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (last_iter) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = accept ? CALC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Mul: acc = {partial product, remaining multiplier bits}, opd = multiplicand.
    // Div: acc = {partial remainder, dividend bits / quotient bits}, opd = divisor.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opd : {WIDTH{1'b0}})};
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opd};
        calc_nxt  = {mul_sum, acc[WIDTH-1:1]};
        if (op_r[1]) begin
            if (!div_trial[WIDTH]) calc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                   calc_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    // neg_a/neg_b are only set for signed ops, so no extra op gating here.
    always_comb begin
        prod   = (neg_a ^ neg_b) ? -acc : acc;
        res_lo = prod[WIDTH-1:0];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_dz = 1'b0;
        if (op_r[1]) begin
            if (opd == '0) begin
                res_lo = '1;
                res_hi = a_r;
                res_dz = 1'b1;
            end else begin
                res_lo = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                res_hi = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_r  <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            a_r   <= '0;
            opd   <= '0;
            acc   <= '0;
            cnt   <= '0;
            lo_r  <= '0;
            hi_r  <= '0;
            dz_r  <= 1'b0;
        end else begin
            if (accept) begin
                op_r  <= bus.op;
                neg_a <= bus.op[0] & bus.a[WIDTH-1];
                neg_b <= bus.op[0] & bus.b[WIDTH-1];
                a_r   <= bus.a;
                opd   <= bus.op[1] ? mag_b : mag_a;
                acc   <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                cnt   <= '0;
            end else if (state == CALC) begin
                acc <= calc_nxt;
                cnt <= cnt + CNT_W'(1);
            end
            if (state == FIX) begin
                lo_r <= res_lo;
                hi_r <= res_hi;
                dz_r <= res_dz;
            end
        end
    end
endmodule

// File: tb/tb_c16_mdu.sv
// Directed bench for c16_mdu (WIDTH=16) with hand-computed expected results.
// Cycle numbering: the cycle right after the start edge is cycle 1; done is expected in cycle 18.
module tb_c16_mdu;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    c16_mdu_if #(.WIDTH(16)) bus ();
    c16_mdu #(.WIDTH(16), .CNT_W(5)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for done from cycle 1 onward; returns the cycle index done was seen in (40 = timeout).
    task automatic wait_done(output int lat);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Called #1 after an edge (or on a negedge); scrambles inputs after the sampling edge.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] lo, output logic [15:0] hi, output logic dz,
                          output int lat);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = ~op; bus.a = 16'hA5A5; bus.b = 16'h5A5A;
        wait_done(lat);
        lo = bus.lo; hi = bus.hi; dz = bus.dz;
        @(posedge clk); #1;
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [15:0] a, b, lo, hi;
        logic        dz;
    } vec_t;

    vec_t vecs[$] = '{
        '{"mulu_ffff", 2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0},
        '{"muls_m3x5", 2'b01, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 1'b0},
        '{"divs_m7d2", 2'b11, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0},
        '{"divu_dz",   2'b10, 16'h0064, 16'h0000, 16'hFFFF, 16'h0064, 1'b1},
        '{"divu_100_7",2'b10, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0},
        '{"divs_ovf",  2'b11, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0},
        '{"divs_7dm2", 2'b11, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0},
        '{"divs_dz",   2'b11, 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1},
        '{"muls_mxm",  2'b01, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0},
        '{"mulu_zero", 2'b00, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0}
    };

    initial begin
        logic [15:0] lo, hi;
        logic        dz;
        int          lat, d0;

        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_lo", bus.lo, 16'h0);
        chk("rst_hi", bus.hi, 16'h0);
        chk("rst_dz", bus.dz, 1'b0);

        // First request accepted at the first edge after reset release.
        @(negedge clk);
        resetn = 1'b1;
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lo, hi, dz, lat);
            chk({vecs[i].name, "_lat"}, lat, 18);
            chk({vecs[i].name, "_lo"}, lo, vecs[i].lo);
            chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
            chk({vecs[i].name, "_dz"}, dz, vecs[i].dz);
            chk({vecs[i].name, "_hold_lo"}, bus.lo, vecs[i].lo);
        end

        // Start while busy is ignored; start in the DONE cycle is accepted.
        d0 = done_cnt;
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'd3; bus.b = 16'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("bb_busy", bus.busy, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 16'd9; bus.b = 16'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 6;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bb_first_lat", lat, 18);
        chk("bb_first_lo", bus.lo, 16'h000C);
        chk("bb_first_hi", bus.hi, 16'h0000);
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 16'd2; bus.b = 16'hFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = 16'h7777; bus.b = 16'h7777;
        chk("bb_reaccept_busy", bus.busy, 1'b1);
        wait_done(lat);
        chk("bb_second_lat", lat, 18);
        chk("bb_second_lo", bus.lo, 16'hFFFE);
        chk("bb_second_hi", bus.hi, 16'hFFFF);
        repeat (20) @(posedge clk);
        #1;
        chk("bb_done_count", done_cnt - d0, 2);

        // Reset in cycle 8 of a mulu aborts it with no done pulse.
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'd5; bus.b = 16'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        d0 = done_cnt;
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_lo", bus.lo, 16'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt - d0, 0);
        chk("mid_rst_lo_after", bus.lo, 16'h0);
        chk("mid_rst_hi_after", bus.hi, 16'h0);
        run_op(2'b00, 16'd2, 16'd2, lo, hi, dz, lat);
        chk("post_rst_lat", lat, 18);
        chk("post_rst_lo", lo, 16'h0004);
        chk("post_rst_hi", hi, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
